// File: rtl/gb_pkg.sv
// Shared types for the memory controller: address/data widths and DMA states.
package gb_pkg;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        DONE
    } dma_state_t;

endpackage

// File: rtl/mem_dma.sv
// Block-copy DMA sequencer: latches a copy request and walks it one byte
// per granted cycle, exporting its request, addresses and completion pulse.
module mem_dma
    import gb_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  addr_t            src,
    input  addr_t            dst,
    input  logic [LEN_W-1:0] len,
    input  logic             gnt,
    output logic             req,
    output addr_t            read_addr,
    output addr_t            write_addr,
    output logic             busy,
    output logic             done
);

    dma_state_t       state;
    dma_state_t       state_n;
    addr_t            src_q;
    addr_t            dst_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] idx_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (state == IDLE && start) begin
                src_q <= src;
                dst_q <= dst;
                len_q <= len;
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        req     = 1'b0;
        done    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    idx_n   = '0;
                    state_n = (len == '0) ? DONE : COPY;
                end
            end
            COPY: begin
                req = 1'b1;
                if (gnt) begin
                    idx_n = idx + 1'b1;
                    if (idx == len_q - 1'b1) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Offsets wrap modulo the address width.
    assign read_addr  = src_q + addr_t'(idx);
    assign write_addr = dst_q + addr_t'(idx);
    assign busy       = (state != IDLE);

endmodule

// File: rtl/mem_ctrl.sv
// Shares one memory port between CPU accesses and the copy engine with
// round-robin arbitration on conflicts, and registers CPU read data.
module mem_ctrl
    import gb_pkg::*;
#(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  addr_t            cpu_addr,
    input  data_t            cpu_wdata,
    output logic             cpu_gnt,
    output logic             cpu_rvalid,
    output data_t            cpu_rdata,
    input  logic             dma_start,
    input  addr_t            dma_src,
    input  addr_t            dma_dst,
    input  logic [LEN_W-1:0] dma_len,
    output logic             dma_busy,
    output logic             dma_done,
    output logic             mem_wen,
    output addr_t            mem_read_addr,
    output addr_t            mem_write_addr,
    output data_t            mem_write_data,
    input  data_t            mem_read_data
);

    logic  rr;
    logic  dma_req;
    logic  dma_gnt;
    addr_t dma_raddr;
    addr_t dma_waddr;

    mem_dma #(
        .LEN_W(LEN_W)
    ) u_dma (
        .clk       (clk),
        .rst       (rst),
        .start     (dma_start),
        .src       (dma_src),
        .dst       (dma_dst),
        .len       (dma_len),
        .gnt       (dma_gnt),
        .req       (dma_req),
        .read_addr (dma_raddr),
        .write_addr(dma_waddr),
        .busy      (dma_busy),
        .done      (dma_done)
    );

    // rr=0 favours the CPU on the next conflict, rr=1 favours the DMA.
    assign cpu_gnt = !rst && cpu_req && (!dma_req || !rr);
    assign dma_gnt = !rst && dma_req && (!cpu_req || rr);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr         <= 1'b0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            if (cpu_req && dma_req) begin
                rr <= ~rr;
            end
            cpu_rvalid <= cpu_gnt && !cpu_we;
            if (cpu_gnt && !cpu_we) begin
                cpu_rdata <= mem_read_data;
            end
        end
    end

    always_comb begin
        mem_wen        = 1'b0;
        mem_read_addr  = '0;
        mem_write_addr = '0;
        mem_write_data = '0;
        if (dma_gnt) begin
            mem_wen        = 1'b1;
            mem_read_addr  = dma_raddr;
            mem_write_addr = dma_waddr;
            mem_write_data = mem_read_data;
        end else if (cpu_gnt) begin
            if (cpu_we) begin
                mem_wen        = 1'b1;
                mem_write_addr = cpu_addr;
                mem_write_data = cpu_wdata;
            end else begin
                mem_read_addr = cpu_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural memory and a read scoreboard.
module tb_mem_ctrl;
    import gb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    addr_t       cpu_addr;
    data_t       cpu_wdata;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    data_t       cpu_rdata;
    logic        dma_start;
    addr_t       dma_src;
    addr_t       dma_dst;
    logic [7:0]  dma_len;
    logic        dma_busy;
    logic        dma_done;
    logic        mem_wen;
    addr_t       mem_read_addr;
    addr_t       mem_write_addr;
    data_t       mem_write_data;
    data_t       mem_read_data;

    logic [7:0]  mem [0:65535];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wen_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          first_wen = -1;
    int          last_wen = -1;
    int          t0;
    int          seen;
    bit          logging = 1'b0;
    data_t       exp_rd = '0;
    data_t       sb[$];
    logic        gnt_log[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wen) mem[mem_write_addr] <= mem_write_data;
    end
    assign mem_read_data = mem[mem_read_addr];

    mem_ctrl #(.LEN_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_gnt       (cpu_gnt),
        .cpu_rvalid    (cpu_rvalid),
        .cpu_rdata     (cpu_rdata),
        .dma_start     (dma_start),
        .dma_src       (dma_src),
        .dma_dst       (dma_dst),
        .dma_len       (dma_len),
        .dma_busy      (dma_busy),
        .dma_done      (dma_done),
        .mem_wen       (mem_wen),
        .mem_read_addr (mem_read_addr),
        .mem_write_addr(mem_write_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sample mid-cycle, then advance past the next rising edge.
    task automatic step();
        @(negedge clk);
        if (cpu_rvalid) begin
            if (sb.size() == 0) chk("rvalid_unexpected", 32'd1, 32'd0);
            else chk("rdata_sb", 32'(cpu_rdata), 32'(sb.pop_front()));
        end
        if (cpu_gnt && !cpu_we) sb.push_back(exp_rd);
        if (mem_wen) begin
            wen_cnt++;
            if (first_wen < 0) first_wen = cyc;
            last_wen = cyc;
        end
        if (dma_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (logging && dma_busy) gnt_log.push_back(cpu_gnt);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic cpu_write(input addr_t a, input data_t d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic start_dma(input addr_t s, input addr_t d,
                             input logic [7:0] n);
        dma_start = 1'b1; dma_src = s; dma_dst = d; dma_len = n;
        wen_cnt = 0; first_wen = -1; last_wen = -1;
        t0 = cyc;
        seen = done_cnt;
        step();
        dma_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done_cnt == seen && n < 40) begin
            step();
            n++;
        end
        if (done_cnt == seen) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'hEE;
        dma_start = 1'b0; dma_src = '0; dma_dst = '0; dma_len = '0;
        step();
        #1;
        chk("rst_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst_wen", 32'(mem_wen), 32'd0);
        step();
        chk("rst_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_busy", 32'(dma_busy), 32'd0);
        chk("rst_done", 32'(dma_done), 32'd0);
        cpu_req = 1'b0; cpu_we = 1'b0;
        rst = 1'b0;
        step();

        // CPU write then read
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h5A;
        #1 chk("wr_gnt", 32'(cpu_gnt), 32'd1);
        step();
        cpu_we = 1'b0; exp_rd = 8'h5A;
        #1 chk("rd_gnt", 32'(cpu_gnt), 32'd1);
        step();
        cpu_req = 1'b0;
        chk("rd_rvalid", 32'(cpu_rvalid), 32'd1);
        chk("rd_rdata", 32'(cpu_rdata), 32'h5A);
        step();
        chk("rd_rvalid_pulse", 32'(cpu_rvalid), 32'd0);

        cpu_write(16'h0000, 8'h11);
        cpu_write(16'h0001, 8'h22);
        cpu_write(16'h0002, 8'h33);
        cpu_write(16'h0003, 8'h44);

        // Unopposed copy of 4 bytes
        start_dma(16'h0000, 16'h0100, 8'd4);
        chk("cp_busy", 32'(dma_busy), 32'd1);
        wait_done("cp");
        chk("cp_done_cyc", 32'(done_cyc - t0), 32'd5);
        chk("cp_first_wen", 32'(first_wen - t0), 32'd1);
        chk("cp_last_wen", 32'(last_wen - t0), 32'd4);
        chk("cp_wen_cnt", 32'(wen_cnt), 32'd4);
        chk("cp_busy_low", 32'(dma_busy), 32'd0);
        chk("cp_m100", 32'(mem[16'h0100]), 32'h11);
        chk("cp_m101", 32'(mem[16'h0101]), 32'h22);
        chk("cp_m102", 32'(mem[16'h0102]), 32'h33);
        chk("cp_m103", 32'(mem[16'h0103]), 32'h44);

        // Same copy against a CPU read held every cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000; exp_rd = 8'h11;
        gnt_log.delete();
        logging = 1'b1;
        start_dma(16'h0000, 16'h0100, 8'd4);
        wait_done("ct");
        logging = 1'b0;
        cpu_req = 1'b0;
        chk("ct_done_cyc", 32'(done_cyc - t0), 32'd9);
        chk("ct_log_len", 32'(gnt_log.size()), 32'd9);
        for (int i = 0; i < 8 && i < gnt_log.size(); i++) begin
            chk($sformatf("ct_gnt%0d", i), 32'(gnt_log[i]),
                32'((i % 2) == 0));
        end
        chk("ct_wen_cnt", 32'(wen_cnt), 32'd4);
        step();
        step();
        chk("ct_sb_empty", 32'(sb.size()), 32'd0);

        // Zero-length copy
        start_dma(16'h0000, 16'h0400, 8'd0);
        wait_done("z");
        chk("z_done_cyc", 32'(done_cyc - t0), 32'd1);
        chk("z_wen_cnt", 32'(wen_cnt), 32'd0);

        // Overlapping forward copy
        cpu_write(16'h0000, 8'hAA);
        start_dma(16'h0000, 16'h0001, 8'd3);
        wait_done("ov");
        chk("ov_m1", 32'(mem[16'h0001]), 32'hAA);
        chk("ov_m2", 32'(mem[16'h0002]), 32'hAA);
        chk("ov_m3", 32'(mem[16'h0003]), 32'hAA);

        // Reset in the middle of a copy
        cpu_write(16'h0202, 8'h00);
        cpu_write(16'h0203, 8'h00);
        start_dma(16'h0100, 16'h0200, 8'd4);
        step();
        step();
        rst = 1'b1;
        #1 chk("ra_wen_in_rst", 32'(mem_wen), 32'd0);
        step();
        rst = 1'b0;
        chk("ra_busy", 32'(dma_busy), 32'd0);
        step();
        step();
        chk("ra_no_done", 32'(done_cnt - seen), 32'd0);
        chk("ra_wen_cnt", 32'(wen_cnt), 32'd2);
        chk("ra_m200", 32'(mem[16'h0200]), 32'h11);
        chk("ra_m201", 32'(mem[16'h0201]), 32'h22);
        chk("ra_m202", 32'(mem[16'h0202]), 32'h00);
        chk("ra_m203", 32'(mem[16'h0203]), 32'h00);

        start_dma(16'h0102, 16'h0300, 8'd2);
        chk("rs_busy", 32'(dma_busy), 32'd1);
        wait_done("rs");
        chk("rs_done_cyc", 32'(done_cyc - t0), 32'd3);
        chk("rs_m300", 32'(mem[16'h0300]), 32'h33);
        chk("rs_m301", 32'(mem[16'h0301]), 32'h44);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller that shares the single-write-port, combinational-read memory between the CPU access port and an internal block-copy DMA engine. It arbitrates one memory transaction per cycle, issues CPU reads and writes, and sequences DMA copies of up to 2^LEN_W-1 bytes at one byte per granted cycle. It sits between the CPU bus and the memory instance, and drives every memory-side control and address signal.

## Interface
- LEN_W, default 8: width of the DMA length field.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU requests an access this cycle.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  addr_t  CPU address.
- cpu_wdata  in  data_t  CPU write data.
- cpu_gnt  out  1  combinational; the access is performed this cycle.
- cpu_rvalid  out  1  registered; 1-cycle pulse, the read data is valid.
- cpu_rdata  out  data_t  registered; last granted read data, held until the next granted read.
- dma_start  in  1  start a copy; sampled only in IDLE.
- dma_src, dma_dst  in  addr_t  source and destination base addresses.
- dma_len  in  LEN_W  byte count.
- dma_busy  out  1  high in COPY and DONE.
- dma_done  out  1  1-cycle completion pulse.
- mem_wen  out  1  memory write enable.
- mem_read_addr, mem_write_addr  out  addr_t  memory addresses.
- mem_write_data  out  data_t  memory write data.
- mem_read_data  in  data_t  combinational read data from memory.

## Operation
- DMA FSM states:
  - IDLE: on dma_start, latch src, dst and len, clear idx, then go to COPY. If len==0, go straight to DONE.
  - COPY: while DMA holds the grant, mem_read_addr=src+idx, mem_write_addr=dst+idx, mem_write_data=mem_read_data, mem_wen=1, and idx increments. After the grant with idx==len-1, go to DONE.
  - DONE: dma_done=1, then go to IDLE.
- dma_start is ignored outside IDLE.
- Address arithmetic wraps modulo the addr_t width.
- Overlapping ranges copy forward byte by byte. A destination byte that is later read as a source returns the copied value.
- Arbitration:
  - DMA requests in every COPY cycle.
  - With a single requester, that requester wins.
  - On a conflict, round-robin: the loser of the previous conflict wins. The rr pointer flips only on conflict cycles.
  - After reset, the first conflict goes to CPU.
- CPU granted write: mem_wen=1, mem_write_addr=cpu_addr, mem_write_data=cpu_wdata.
- CPU granted read: mem_read_addr=cpu_addr. cpu_rdata is registered from mem_read_data.
- When nothing is granted: mem_wen=0 and all addresses are 0.
- While rst is high: mem_wen=0, cpu_gnt=0, no memory write occurs.
- Reset values: state IDLE, idx 0, rr = CPU-first, and cpu_rvalid, cpu_rdata, dma_busy, dma_done all 0.
- Reset during COPY abandons the copy with no done pulse. Bytes already written stay written.

## Timing
- CPU write: takes effect at the clock edge of its grant cycle.
- CPU read: granted at cycle T gives cpu_rvalid and cpu_rdata at T+1.
- CPU back-to-back reads: accepted every cycle.
- dma_start at T: dma_busy from T+1.
- Unopposed copy of N bytes: writes at T+1..T+N, dma_done at T+N+1, dma_busy low at T+N+2.
- Each conflict cycle lost to the CPU delays dma_done by one cycle.
- Under continuous CPU contention, each side gets every other cycle.
- len==0: dma_done at T+1 with no writes.

## Structure
- Shared package gb_pkg: addr_t (16-bit), data_t (8-bit), and the DMA state enum.
- The optional sub-module mem_dma holds the FSM, latched parameters and idx. It exports its request, read/write addresses and done.
- mem_ctrl holds the arbiter, rr pointer, memory muxing and the CPU read register.

## Test plan
- Reset, then CPU write 0x5A to 0x0010, then CPU read 0x0010: cpu_gnt=1 both cycles, and one cycle later cpu_rvalid=1, cpu_rdata=0x5A.
- Preload 0x0000..0x0003 = 11,22,33,44. dma_start src=0x0000 dst=0x0100 len=4 with no CPU traffic: writes at T+1..T+4, dma_done at T+5, memory 0x0100..0x0103 = 11,22,33,44.
- Same copy with cpu_req reading 0x0000 held every cycle:
  - Grants alternate, with CPU taking the first conflict.
  - dma_done arrives at T+9.
  - Every CPU read returns 11.
- dma_len=0: dma_done at T+1, mem_wen never high.
- Overlap: src=0x0000, dst=0x0001, len=3, memory[0]=AA: 0x0001..0x0003 all become AA.
- Assert rst during COPY after 2 bytes:
  - No dma_done.
  - Only the first 2 destination bytes are written.
  - dma_busy=0 the cycle after rst.
  - A new dma_start is accepted afterwards.
